// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART serializer. Bytes pushed on wr leave on tx
// LSB first, back to back while the FIFO holds data, idle-high otherwise.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH_LOG2   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]       BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  state_t                r_state;
  state_t                w_state_next;
  logic [BW-1:0]         r_baud;
  logic [BW-1:0]         w_baud_next;
  logic [2:0]            r_bit_idx;
  logic [2:0]            w_bit_idx_next;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_next;
  logic                  r_tx;

  logic                  w_full;
  logic                  w_not_empty;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_baud_done;

  assign w_full      = (r_count == FULL_CNT);
  assign w_not_empty = (r_count != '0);
  // Fullness is judged before any same-cycle pop, so a write into a full
  // FIFO is dropped even while the serializer is draining it.
  assign w_push      = wr && !w_full;
  assign w_drop      = wr && w_full;
  assign w_baud_done = (r_baud == BAUD_MAX);

  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (w_not_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_head];
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_next    = '0;
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_next = '0;
          if (w_not_empty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_head];
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: storage is left out of reset; pointers and count alone define
  // which entries are valid, and a resettable array would cost flops.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= din;
  end

  // tx is registered from the current state, so the line lags the FSM by
  // one cycle while every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign ready    = !w_full;
  assign busy     = w_not_empty || (r_state != S_IDLE);
  assign tx       = r_tx;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: edge-indexed stimulus with a small
// frame model giving the expected tx level at every edge.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DL2   = 3;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       wr;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_bytes [16];
  logic       etx;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .wr       (wr),
    .ready    (ready),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected tx after edge e when n queued frames run contiguously and the
  // first pop happens at edge p0 (line goes low one edge later).
  function automatic logic exp_tx(input int e, input int p0, input int n);
    int o;
    int k;
    int r;
    o = e - (p0 + 1);
    if (o < 0 || o >= FRAME * n) return 1'b1;
    k = o / FRAME;
    r = o % FRAME;
    if (r < CPB) return 1'b0;
    if (r < 9 * CPB) return exp_bytes[k][(r - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr  = 1'b0;
    din = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    wr  = 1'b0;
    din = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    tick();
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    exp_bytes[0] = 8'hA5;
    for (int e = 0; e <= 45; e++) begin
      wr  = (e == 0);
      din = 8'hA5;
      tick();
      etx = exp_tx(e, 1, 1);
      checks++; if (tx !== etx) begin errors++; $display("FAIL single_tx e=%0d got=%b exp=%b", e, tx, etx); end
      if (e == 1 || e == 40) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy e=%0d got=%b exp=1", e, busy); end
      end
      if (e == 42 || e == 45) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle e=%0d got=%b exp=0", e, busy); end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_bytes[0] = 8'h01;
    exp_bytes[1] = 8'h80;
    exp_bytes[2] = 8'hFF;
    for (int e = 0; e <= 125; e++) begin
      wr  = (e < 3);
      din = (e < 3) ? exp_bytes[e] : 8'h00;
      tick();
      etx = exp_tx(e, 1, 3);
      checks++; if (tx !== etx) begin errors++; $display("FAIL b2b_tx e=%0d got=%b exp=%b", e, tx, etx); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready e=%0d got=%b exp=1", e, ready); end
      if (e == 120) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy e=%0d got=%b exp=1", e, busy); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) exp_bytes[i] = 8'(i);
    for (int e = 0; e <= 370; e++) begin
      wr  = (e < 10);
      din = 8'(e);
      tick();
      etx = exp_tx(e, 1, 9);
      checks++; if (tx !== etx) begin errors++; $display("FAIL ovf_tx e=%0d got=%b exp=%b", e, tx, etx); end
      if (e == 7 || e == 41) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ovf_ready e=%0d got=%b exp=1", e, ready); end
      end
      if (e == 8 || e == 9 || e == 40) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ovf_full e=%0d got=%b exp=0", e, ready); end
      end
      if (e == 8) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early e=%0d got=%b exp=0", e, overflow); end
      end
      if (e == 9 || e == 200) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag e=%0d got=%b exp=1", e, overflow); end
      end
    end
    checks++; if (busy !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_end busy=%b overflow=%b exp busy=0 overflow=1", busy, overflow);
    end
    do_reset();
    checks++; if (overflow !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL ovf_clear overflow=%b ready=%b exp overflow=0 ready=1", overflow, ready);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 9; i++) exp_bytes[i] = 8'(8'h10 + i);
    for (int e = 0; e <= 370; e++) begin
      wr  = (e < 9) || (e == 41);
      din = (e < 9) ? exp_bytes[e] : 8'hEE;
      tick();
      etx = exp_tx(e, 1, 9);
      checks++; if (tx !== etx) begin errors++; $display("FAIL fullpop_tx e=%0d got=%b exp=%b", e, tx, etx); end
      if (e == 40) begin
        checks++; if (ready !== 1'b0 || overflow !== 1'b0) begin
          errors++; $display("FAIL fullpop_pre e=%0d ready=%b overflow=%b exp 0 0", e, ready, overflow);
        end
      end
      if (e == 41 || e == 42) begin
        checks++; if (ready !== 1'b1 || overflow !== 1'b1) begin
          errors++; $display("FAIL fullpop_post e=%0d ready=%b overflow=%b exp 1 1", e, ready, overflow);
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fullpop_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    exp_bytes[0] = 8'h11;
    exp_bytes[1] = 8'h22;
    exp_bytes[2] = 8'h33;
    for (int e = 0; e <= 120; e++) begin
      wr  = (e < 3);
      din = (e < 3) ? exp_bytes[e] : 8'h00;
      rst = (e == 19);
      tick();
      if (e < 19) begin
        etx = exp_tx(e, 1, 3);
        checks++; if (tx !== etx) begin errors++; $display("FAIL midrst_tx e=%0d got=%b exp=%b", e, tx, etx); end
      end else if (e == 19) begin
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL midrst_txhi got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", overflow); end
      end else begin
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL midrst_quiet e=%0d tx=%b busy=%b exp tx=1 busy=0", e, tx, busy);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_stop_write();
    do_reset();
    exp_bytes[0] = 8'h3C;
    exp_bytes[1] = 8'h55;
    for (int e = 0; e <= 90; e++) begin
      wr  = (e == 0) || (e == 38);
      din = (e == 0) ? 8'h3C : 8'h55;
      tick();
      etx = exp_tx(e, 1, 2);
      checks++; if (tx !== etx) begin errors++; $display("FAIL stopwr_tx e=%0d got=%b exp=%b", e, tx, etx); end
      if (e == 41) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stopwr_busy e=%0d got=%b exp=1", e, busy); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stopwr_idle got=%b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    wr  = 1'b0;
    din = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_stop_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
